// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller
// Timed phase sequencer for a two-road intersection (main and side road),
// with all-red clearance, a pedestrian walk phase and an advance enable.
//
// Optional feature: define TRAFFIC_NIGHT_FLASH_EN to add the `night` input
// and the FLASH state, where both heads blink yellow.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   en         advance enable; 0 freezes state, timer and outputs
//   ped_req    pedestrian request (level or pulse), latched into ped_pend
//   night      (TRAFFIC_NIGHT_FLASH_EN only) request night flashing
//   main_light main-road head, one-hot RED=100 GREEN=010 YELLOW=001
//   side_light side-road head, same encoding
//   walk       pedestrian walk lamp
//   phase      current state code (MG=0 .. FLASH=7)
//   ped_pend   a latched pedestrian request is waiting
module traffic_phase_controller #(
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 1,
  parameter int WALK_CYC   = 5,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ped_req,
`ifdef TRAFFIC_NIGHT_FLASH_EN
  input  logic       night,
`endif
  output logic [0:2] main_light,
  output logic [0:2] side_light,
  output logic       walk,
  output logic [2:0] phase,
  output logic       ped_pend
);

  typedef enum logic [2:0] {
    S_MG    = 3'd0,
    S_MY    = 3'd1,
    S_AR1   = 3'd2,
    S_SG    = 3'd3,
    S_SY    = 3'd4,
    S_AR2   = 3'd5,
    S_WALK  = 3'd6,
    S_FLASH = 3'd7
  } state_t;

  localparam logic [0:2] L_RED = 3'b100;
  localparam logic [0:2] L_GRN = 3'b010;
  localparam logic [0:2] L_YEL = 3'b001;
  localparam logic [0:2] L_OFF = 3'b000;

  localparam logic [CNT_W-1:0] G_LD = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] Y_LD = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] A_LD = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] W_LD = CNT_W'(WALK_CYC - 1);

  state_t           state_p0, state_nx;
  logic [CNT_W-1:0] tmr_p0, tmr_nx;
  logic             flash_on_p0, flash_on_nx;
  logic             pend_nx;
  logic [0:2]       main_nx, side_nx;
  logic             walk_nx;
  logic             night_w;
  logic             go_walk;

`ifdef TRAFFIC_NIGHT_FLASH_EN
  assign night_w = night;
`else
  assign night_w = 1'b0;
`endif

  // Timer reload value on entry to a state. FLASH half-periods reuse the
  // yellow duration.
  function automatic logic [CNT_W-1:0] load_val(input state_t s);
    case (s)
      S_MG, S_SG:   load_val = G_LD;
      S_MY, S_SY:   load_val = Y_LD;
      S_WALK:       load_val = W_LD;
      S_FLASH:      load_val = Y_LD;
      default:      load_val = A_LD;
    endcase
  endfunction

  // Pending request or a request arriving on this very edge both count, so a
  // late request during the last AR2 cycle is still honoured.
  assign go_walk = ped_pend | ped_req;

  always_comb begin
    state_nx    = state_p0;
    tmr_nx      = tmr_p0;
    flash_on_nx = flash_on_p0;
    if (en) begin
      if (tmr_p0 == '0) begin
        if (night_w) begin
          state_nx    = S_FLASH;
          // Staying in FLASH toggles the half-period; entering starts on yellow.
          flash_on_nx = (state_p0 == S_FLASH) ? ~flash_on_p0 : 1'b1;
        end else begin
          case (state_p0)
            S_MG:    state_nx = S_MY;
            S_MY:    state_nx = S_AR1;
            S_AR1:   state_nx = S_SG;
            S_SG:    state_nx = S_SY;
            S_SY:    state_nx = S_AR2;
            S_AR2:   state_nx = go_walk ? S_WALK : S_MG;
            S_WALK:  state_nx = S_MG;
            S_FLASH: state_nx = S_AR2;
            default: state_nx = S_AR2;
          endcase
        end
        tmr_nx = load_val(state_nx);
      end else begin
        tmr_nx = tmr_p0 - 1'b1;
      end
    end
    // Entering WALK consumes the request and wins over a coincident ped_req;
    // requests seen while already in WALK are dropped.
    if (state_nx == S_WALK && state_p0 != S_WALK)
      pend_nx = 1'b0;
    else
      pend_nx = ped_pend | (ped_req & (state_p0 != S_WALK));
  end

  // Outputs are decoded from the next state so the registered lamps change on
  // the same edge as the state register.
  always_comb begin
    main_nx = L_RED;
    side_nx = L_RED;
    walk_nx = 1'b0;
    case (state_nx)
      S_MG:    main_nx = L_GRN;
      S_MY:    main_nx = L_YEL;
      S_SG:    side_nx = L_GRN;
      S_SY:    side_nx = L_YEL;
      S_WALK:  walk_nx = 1'b1;
      S_FLASH: begin
        main_nx = flash_on_nx ? L_YEL : L_OFF;
        side_nx = flash_on_nx ? L_YEL : L_OFF;
      end
      default: ;
    endcase
  end

  // Stage p0: state, timer, latch and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p0    <= S_AR2;
      tmr_p0      <= A_LD;
      flash_on_p0 <= 1'b0;
      ped_pend    <= 1'b0;
      main_light  <= L_RED;
      side_light  <= L_RED;
      walk        <= 1'b0;
      phase       <= S_AR2;
    end else begin
      state_p0    <= state_nx;
      tmr_p0      <= tmr_nx;
      flash_on_p0 <= flash_on_nx;
      ped_pend    <= pend_nx;
      main_light  <= main_nx;
      side_light  <= side_nx;
      walk        <= walk_nx;
      phase       <= state_nx;
    end
  end

endmodule

// File: tb/tb_traffic_phase_controller.sv
module tb_traffic_phase_controller;

  localparam int G = 8;
  localparam int Y = 3;
  localparam int A = 1;
  localparam int W = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       ped_req = 1'b0;
  logic       night = 1'b0;
  logic [0:2] main_light, side_light;
  logic       walk, ped_pend;
  logic [2:0] phase;

  traffic_phase_controller #(
    .GREEN_CYC(G), .YELLOW_CYC(Y), .ALLRED_CYC(A), .WALK_CYC(W), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .ped_req(ped_req),
`ifdef TRAFFIC_NIGHT_FLASH_EN
    .night(night),
`endif
    .main_light(main_light),
    .side_light(side_light),
    .walk(walk),
    .phase(phase),
    .ped_pend(ped_pend)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cnum = 0;

  // Reference model: phase index, enabled cycles spent in it, latch, flash half.
  int m_ph = 5;
  int m_el = 0;
  bit m_pend = 1'b0;
  bit m_fon = 1'b0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cnum, got, exp);
    end
  endtask

  function automatic int dur(input int p);
    case (p)
      0, 3:    return G;
      1, 4, 7: return Y;
      6:       return W;
      default: return A;
    endcase
  endfunction

  function automatic logic [2:0] exp_main(input int p, input bit fon);
    case (p)
      0:       return 3'b010;
      1:       return 3'b001;
      7:       return fon ? 3'b001 : 3'b000;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_side(input int p, input bit fon);
    case (p)
      3:       return 3'b010;
      4:       return 3'b001;
      7:       return fon ? 3'b001 : 3'b000;
      default: return 3'b100;
    endcase
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit p, input bit n);
    int pre;
    int nxt;
    bit into_walk;
    pre = m_ph;
    into_walk = 1'b0;
    if (!r) begin
      m_ph = 5; m_el = 0; m_pend = 1'b0; m_fon = 1'b0;
      return;
    end
    if (e) begin
      m_el++;
      if (m_el == dur(m_ph)) begin
        m_el = 0;
        if (n) begin
          nxt = 7;
          m_fon = (m_ph == 7) ? !m_fon : 1'b1;
        end else begin
          case (m_ph)
            5:       nxt = (m_pend || p) ? 6 : 0;
            6:       nxt = 0;
            7:       nxt = 5;
            default: nxt = m_ph + 1;
          endcase
        end
        into_walk = (nxt == 6);
        m_ph = nxt;
      end
    end
    m_pend = into_walk ? 1'b0 : (m_pend || (p && pre != 6));
  endtask

  task automatic compare();
    logic both_lit;
    chk("phase", 8'(phase), 8'(m_ph));
    chk("main", 8'(main_light), 8'(exp_main(m_ph, m_fon)));
    chk("side", 8'(side_light), 8'(exp_side(m_ph, m_fon)));
    chk("walk", 8'(walk), 8'(m_ph == 6));
    chk("ped_pend", 8'(ped_pend), 8'(m_pend));
    if (m_ph != 7) begin
      both_lit = (main_light != 3'b100) && (side_light != 3'b100);
      chk("not_both_go", 8'(both_lit), 8'd0);
    end
  endtask

  // One clock: drive inputs for the current cycle, apply the edge to the model,
  // then check outputs mid-cycle of the following cycle.
  task automatic cyc(input bit r, input bit e, input bit p, input bit n);
    rst_n = r; en = e; ped_req = p; night = n;
    @(posedge clk);
    model_edge(r, e, p, n);
    @(negedge clk);
    cnum++;
    compare();
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cnum = 0;
  endtask

  function automatic int spec_phase(input int c);
    if (c == 0) return 5;
    if (c <= 8) return 0;
    if (c <= 11) return 1;
    if (c == 12) return 2;
    if (c <= 20) return 3;
    if (c <= 23) return 4;
    if (c == 24) return 5;
    return 0;
  endfunction

  initial begin
    // Reset state
    do_reset();
    chk("rst_phase", 8'(phase), 8'd5);
    chk("rst_main", 8'(main_light), 8'b100);
    chk("rst_side", 8'(side_light), 8'b100);
    chk("rst_walk", 8'(walk), 8'd0);
    chk("rst_pend", 8'(ped_pend), 8'd0);

    // Free-running cycle with no requests
    while (cnum < 26) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("seq_phase", 8'(phase), 8'(spec_phase(cnum)));
    end

    // Single-cycle pedestrian pulse at cycle 3
    do_reset();
    while (cnum < 31) begin
      cyc(1'b1, 1'b1, cnum == 3, 1'b0);
      if (cnum == 4) chk("ped_latched", 8'(ped_pend), 8'd1);
      if (cnum >= 25 && cnum <= 29) begin
        chk("walk_phase", 8'(phase), 8'd6);
        chk("walk_lamp", 8'(walk), 8'd1);
        chk("walk_main", 8'(main_light), 8'b100);
        chk("walk_pend_clr", 8'(ped_pend), 8'd0);
      end
      if (cnum == 30) chk("after_walk", 8'(phase), 8'd0);
    end

    // Enable low for cycles 5-9 during MG
    do_reset();
    while (cnum < 15) begin
      cyc(1'b1, !(cnum >= 5 && cnum <= 9), 1'b0, 1'b0);
      if (cnum == 13) chk("frz_mg", 8'(phase), 8'd0);
      if (cnum == 14) chk("frz_my", 8'(phase), 8'd1);
    end

    // Request held high through WALK
    do_reset();
    while (cnum < 32) begin
      cyc(1'b1, 1'b1, cnum >= 2, 1'b0);
      if (cnum >= 25 && cnum <= 30) chk("held_pend0", 8'(ped_pend), 8'd0);
      if (cnum == 31) chk("held_pend1", 8'(ped_pend), 8'd1);
    end

    // Reset pulse at cycle 15 during SG discards a pending request
    do_reset();
    while (cnum < 18) begin
      cyc(cnum != 15, 1'b1, cnum == 10, 1'b0);
      if (cnum == 15) chk("pre_rst_pend", 8'(ped_pend), 8'd1);
      if (cnum == 16) begin
        chk("mid_rst_phase", 8'(phase), 8'd5);
        chk("mid_rst_pend", 8'(ped_pend), 8'd0);
      end
      if (cnum == 17) chk("mid_rst_mg", 8'(phase), 8'd0);
    end

`ifdef TRAFFIC_NIGHT_FLASH_EN
    // Night flashing from cycle 5, released at cycle 16
    do_reset();
    while (cnum < 20) begin
      cyc(1'b1, 1'b1, 1'b0, cnum >= 5 && cnum < 16);
      if (cnum == 9)  chk("fl_enter", 8'(phase), 8'd7);
      if (cnum == 10) chk("fl_yel", 8'(main_light), 8'b001);
      if (cnum == 13) chk("fl_off", 8'(side_light), 8'b000);
      if (cnum == 16) chk("fl_yel2", 8'(main_light), 8'b001);
      if (cnum == 18) chk("fl_ar2", 8'(phase), 8'd5);
      if (cnum == 19) chk("fl_mg", 8'(phase), 8'd0);
    end
`endif

    // Randomized stimulus against the model
    do_reset();
    begin
      bit nt;
      nt = 1'b0;
      for (int i = 0; i < 3000; i++) begin
`ifdef TRAFFIC_NIGHT_FLASH_EN
        if ($urandom_range(0, 99) < 2) nt = !nt;
`endif
        cyc($urandom_range(0, 199) != 0,
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) == 0,
            nt);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
- Sequencing controller for a two-road intersection: main road and side road, each driven by a 3-lamp head.
- Each lamp head uses the team's one-hot lamp encoding (RED=100, GREEN=010, YELLOW=001, bit 0 = red).
- Replaces free-running one-lamp-per-clock cycling with timed phases, all-red clearance, a pedestrian walk phase and an enable/freeze control.
- Sits between the system tick/enable logic and the lamp drivers.

Parameters:
- GREEN_CYC, 8, enabled cycles spent in each green phase.
- YELLOW_CYC, 3, enabled cycles spent in each yellow phase; also the flash half-period.
- ALLRED_CYC, 1, enabled cycles spent in each all-red clearance phase.
- WALK_CYC, 5, enabled cycles spent in the pedestrian walk phase.
- CNT_W, 8, phase timer width. Every *_CYC value must lie in 1..2^CNT_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  advance enable; when 0, state and timer freeze.
- ped_req  input  1  pedestrian request; sampled every cycle and may be a level or a pulse.
- main_light  output  [0:2]  main-road lamp, one-hot as above.
- side_light  output  [0:2]  side-road lamp, one-hot as above.
- walk  output  1  pedestrian walk lamp.
- phase  output  3  current state code.
- ped_pend  output  1  a latched pedestrian request is waiting.

Behaviour:
- Reset and clocking: one clock; reset is synchronous and active-low.
  - With rst_n=0 at a clk edge: state=AR2, timer=ALLRED_CYC-1, main_light=side_light=RED, walk=0, ped_pend=0, phase=5.
- State codes: MG=0, MY=1, AR1=2, SG=3, SY=4, AR2=5, WALK=6, FLASH=7.
- State outputs:
  - MG: main=GREEN, side=RED.
  - MY: main=YELLOW, side=RED.
  - AR1, AR2: both RED.
  - SG: main=RED, side=GREEN.
  - SY: main=RED, side=YELLOW.
  - WALK: both RED, walk=1.
  - walk=0 in every state except WALK.
- Transition sequence:
  - MG -> MY -> AR1 -> SG -> SY -> AR2.
  - AR2 -> WALK if ped_pend=1, else AR2 -> MG.
  - WALK -> MG.
- Timer:
  - On entry to a state, the timer loads that state's *_CYC-1.
  - On each edge with en=1: if timer=0, take the transition; otherwise decrement the timer.
  - Each state therefore lasts exactly *_CYC enabled cycles.
  - en=0 holds state, timer and outputs unchanged.
- Output timing: all outputs are registered and change on the same edge as the state. There is no combinational path from inputs to outputs.
- Pedestrian latch:
  - ped_pend is set on any edge with ped_req=1, regardless of en.
  - ped_pend is cleared on the edge that enters WALK. Clear wins over a simultaneous ped_req.
  - ped_req asserted while in WALK is ignored.
  - A request arriving during AR2 with timer=0 is honoured at that transition, because the set and the AR2 exit decision use the pre-edge ped_pend OR ped_req.
- Cycle timing with defaults and en=1 held from reset release (cycle 0 = first edge with rst_n=1):
  - AR2: cycle 0.
  - MG: cycles 1-8.
  - MY: cycles 9-11.
  - AR1: cycle 12.
  - SG: cycles 13-20.
  - SY: cycles 21-23.
  - AR2: cycle 24.
  - MG: from cycle 25. The full period is 24 cycles.
- Reset mid-phase: immediate return to the reset state on the next edge. The pedestrian request is discarded.
- Invariant: main_light and side_light are never both non-RED.

Optional Feature:
- Macro: TRAFFIC_NIGHT_FLASH_EN.
- When defined:
  - An extra input port `night` (1 bit) exists.
  - At any transition point (timer=0, en=1) with night=1, the next state is FLASH.
  - In FLASH, both heads show YELLOW and 000 alternately, toggling every YELLOW_CYC enabled cycles. The first half-period is YELLOW.
  - walk=0 in FLASH, and ped_pend keeps latching.
  - At the end of a half-period with night=0, exit to AR2 with timer=ALLRED_CYC-1.
  - FLASH is the only state in which a head output of 000 is legal.
- When undefined: the night port is absent, FLASH is unreachable, and the phase code 7 never appears.

Test Plan:
- Reset release, en=1, no requests:
  - Cycle 0: phase=5.
  - main=GREEN cycles 1-8, YELLOW 9-11, RED 12-24.
  - side=GREEN cycles 13-20, YELLOW 21-23.
  - MG returns at cycle 25.
- ped_req one-cycle pulse at cycle 3:
  - ped_pend=1 from cycle 4.
  - WALK at cycles 25-29 with walk=1 and both heads RED.
  - ped_pend=0 from cycle 25; MG at cycle 30.
- en=0 for cycles 5-9 during MG: phase and outputs frozen; MY begins at cycle 14.
- ped_req held high through WALK:
  - ped_pend is cleared at WALK entry and stays 0 during WALK.
  - It is set again on the first edge after WALK exit, provided ped_req is still high.
- rst_n=0 for one cycle during SG at cycle 15:
  - Cycle 16 shows AR2 with both heads RED and ped_pend=0.
  - MG at cycle 17.
- With TRAFFIC_NIGHT_FLASH_EN defined, night=1 from cycle 5:
  - FLASH entered at cycle 9.
  - Heads show YELLOW for 3 cycles, then 000 for 3 cycles, repeating.
  - night=0 then yields AR2 after the current half-period, then MG.
